multicycle_ctrl: RTL

- Multi-cycle control sequencer for the 19-bit core.
- Steps each instruction through FETCH, DECODE, EXECUTE, optional MEM and WB.
- Drives the instruction and data memory handshakes, the IR load strobe, the PC and register-file write strobes, and the datapath muxes.
- Consumes the instruction-class flags and opcode from the combinational decoder, which is fed from the IR.

---
 rtl/multicycle_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control sequencer for the 19-bit core.
// Steps each instruction through FETCH, DECODE, EXECUTE, optional MEM and WB.
// Ports:
//   clk_i, rst_n_i         clock (rising edge), asynchronous active-low reset
//   run_i                  level enable for instruction execution
//   imem_req_o/rvalid_i    instruction fetch handshake; ir_we_o loads the IR
//   *_type_i, op_i         decoder class flags and opcode (decoded from the IR)
//   branch_taken_i         ALU compare result for branches
//   dmem_req_o/we_o/rvalid_i  data memory handshake (we: 1 = store)
//   pc_we_o, pc_sel_o      PC update strobe and source select
//   rf_we_o, wb_sel_o      register-file write strobe and write-back select
//   state_o, trap_o        current state, sticky fault flag
//   retire_o, instret_o    retire pulse and retired-instruction count
module multicycle_ctrl #(
  parameter logic [3:0]  LOAD_OP     = 4'b0011,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             run_i,
  output logic             imem_req_o,
  input  logic             imem_rvalid_i,
  output logic             ir_we_o,
  input  logic             r_type_i,
  input  logic             i_type_i,
  input  logic             s_type_i,
  input  logic             b_type_i,
  input  logic             u_type_i,
  input  logic             j_type_i,
  input  logic [3:0]       op_i,
  input  logic             branch_taken_i,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  input  logic             dmem_rvalid_i,
  output logic             pc_we_o,
  output logic [1:0]       pc_sel_o,
  output logic             rf_we_o,
  output logic [1:0]       wb_sel_o,
  output logic [2:0]       state_o,
  output logic             trap_o,
  output logic             retire_o,
  output logic [CNT_W-1:0] instret_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_TRAP    = 3'd7
  } state_e;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [7:0]       timer_q, timer_d;
  logic             trap_q, trap_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic   is_load;
  logic   any_class;
  state_e next_instr;

  // Class flags stay valid for the whole instruction because the decoder is
  // fed from the IR, which only changes on ir_we_o.
  assign is_load    = i_type_i && (op_i == LOAD_OP);
  assign any_class  = r_type_i | i_type_i | s_type_i | b_type_i | u_type_i | j_type_i;
  assign next_instr = run_i ? S_FETCH : S_IDLE;

  always_comb begin
    state_d    = state_q;
    timer_d    = '0;   // zero default clears the timer on entry to FETCH/MEM
    imem_req_o = 1'b0;
    ir_we_o    = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    pc_we_o    = 1'b0;
    pc_sel_o   = 2'b00;
    rf_we_o    = 1'b0;
    wb_sel_o   = 2'b00;
    retire_o   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_rvalid_i) begin
          ir_we_o = 1'b1;
          state_d = S_DECODE;
        end else begin
          timer_d = timer_q + 8'd1;
          if (timer_d == TIMEOUT) state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        state_d = any_class ? S_EXECUTE : S_TRAP;
      end
      S_EXECUTE: begin
        if (s_type_i || is_load) begin
          state_d = S_MEM;
        end else if (b_type_i) begin
          pc_we_o  = 1'b1;
          pc_sel_o = branch_taken_i ? 2'b01 : 2'b00;
          retire_o = 1'b1;
          state_d  = next_instr;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = s_type_i;
        // rvalid is checked first so an ack on the expiry cycle still wins
        if (dmem_rvalid_i) begin
          if (s_type_i) begin
            pc_we_o  = 1'b1;
            retire_o = 1'b1;
            state_d  = next_instr;
          end else begin
            state_d = S_WB;
          end
        end else begin
          timer_d = timer_q + 8'd1;
          if (timer_d == TIMEOUT) state_d = S_TRAP;
        end
      end
      S_WB: begin
        rf_we_o  = 1'b1;
        pc_we_o  = 1'b1;
        retire_o = 1'b1;
        if (j_type_i) begin
          wb_sel_o = 2'b10;
          pc_sel_o = 2'b10;
        end else if (u_type_i) begin
          wb_sel_o = 2'b11;
        end else if (is_load) begin
          wb_sel_o = 2'b01;
        end
        state_d = next_instr;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase
    trap_d    = trap_q | (state_d == S_TRAP);
    instret_d = instret_q + CNT_W'(retire_o);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      trap_q    <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      trap_q    <= trap_d;
      instret_q <= instret_d;
    end
  end

  assign state_o   = state_q;
  assign trap_o    = trap_q;
  assign instret_o = instret_q;

endmodule
